// File: rtl/slave_port_burst_split.sv
// slave_port_burst_split: bit-serial bus slave port with burst beats and split on long read latency
module slave_port_burst_split #(
  parameter int ADDR_W       = 12,
  parameter int DATA_W       = 8,
  parameter int BURST_W      = 8,
  parameter int DELAY_W      = 6,
  parameter int SPLIT_THRESH = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [DELAY_W-1:0] slave_delay,
  input  logic               read_en,
  input  logic               write_en,
  input  logic               master_valid,
  input  logic               master_ready,
  input  logic               rx_address,
  input  logic               rx_burst,
  input  logic               rx_data,
  output logic               slave_ready,
  output logic               slave_valid,
  output logic               tx_data,
  output logic               split_en,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [DATA_W-1:0]  mem_wdata,
  output logic               mem_wr_en,
  output logic               mem_rd_en,
  input  logic [DATA_W-1:0]  mem_rdata,
  output logic               busy
);
  localparam int MW = ADDR_W > DATA_W ? ADDR_W : DATA_W;
  localparam int CW = $clog2(MW + 1);
  typedef enum logic [2:0] {IDLE, ADDR, WDATA, RWAIT, RSEND} state_t;
  state_t              state;
  logic                is_write;
  logic [ADDR_W-1:0]   addr_sh;
  logic [BURST_W-1:0]  burst_sh;
  logic [BURST_W-1:0]  beat;
  logic [DATA_W-1:0]   data_sh;
  logic [DATA_W-1:0]   tx_sh;
  logic [CW-1:0]       bit_cnt;
  logic [DELAY_W-1:0]  wait_cnt;
  assign slave_ready = (state == IDLE) || (state == ADDR) || (state == WDATA);
  assign busy        = state != IDLE;
  assign tx_data     = slave_valid & tx_sh[0];
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state       <= IDLE;
      is_write    <= 1'b0;
      addr_sh     <= '0;
      burst_sh    <= '0;
      beat        <= '0;
      data_sh     <= '0;
      tx_sh       <= '0;
      bit_cnt     <= '0;
      wait_cnt    <= '0;
      slave_valid <= 1'b0;
      split_en    <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_wr_en   <= 1'b0;
      mem_rd_en   <= 1'b0;
    end else begin
      mem_wr_en <= 1'b0;
      mem_rd_en <= 1'b0;
      // the address of a finished write beat advances only after its strobe cycle
      if (mem_wr_en && state == WDATA) mem_addr <= mem_addr + 1'b1;
      case (state)
        IDLE: if (master_valid && (read_en || write_en)) begin
          is_write <= write_en;
          addr_sh  <= {rx_address, addr_sh[ADDR_W-1:1]};
          burst_sh <= {rx_burst, burst_sh[BURST_W-1:1]};
          bit_cnt  <= CW'(1);
          state    <= ADDR;
        end
        ADDR: if (master_valid) begin
          addr_sh <= {rx_address, addr_sh[ADDR_W-1:1]};
          if (bit_cnt < CW'(BURST_W)) burst_sh <= {rx_burst, burst_sh[BURST_W-1:1]};
          bit_cnt <= bit_cnt + 1'b1;
          if (bit_cnt == CW'(ADDR_W - 1)) begin
            mem_addr  <= {rx_address, addr_sh[ADDR_W-1:1]};
            bit_cnt   <= '0;
            beat      <= '0;
            wait_cnt  <= (slave_delay == '0) ? DELAY_W'(1) : slave_delay;
            split_en  <= !is_write && (slave_delay >= DELAY_W'(SPLIT_THRESH));
            mem_rd_en <= !is_write;
            state     <= is_write ? WDATA : RWAIT;
          end
        end
        WDATA: if (master_valid) begin
          data_sh <= {rx_data, data_sh[DATA_W-1:1]};
          bit_cnt <= bit_cnt + 1'b1;
          if (bit_cnt == CW'(DATA_W - 1)) begin
            mem_wdata <= {rx_data, data_sh[DATA_W-1:1]};
            mem_wr_en <= 1'b1;
            bit_cnt   <= '0;
            if (beat == burst_sh) state <= IDLE;
            else beat <= beat + 1'b1;
          end
        end
        RWAIT:
          if (wait_cnt <= DELAY_W'(1)) begin
            tx_sh       <= mem_rdata;
            slave_valid <= 1'b1;
            split_en    <= 1'b0;
            bit_cnt     <= '0;
            state       <= RSEND;
          end else wait_cnt <= wait_cnt - 1'b1;
        RSEND: if (master_ready) begin
          tx_sh   <= tx_sh >> 1;
          bit_cnt <= bit_cnt + 1'b1;
          if (bit_cnt == CW'(DATA_W - 1)) begin
            slave_valid <= 1'b0;
            bit_cnt     <= '0;
            if (beat == burst_sh) state <= IDLE;
            else begin
              beat      <= beat + 1'b1;
              mem_addr  <= mem_addr + 1'b1;
              mem_rd_en <= 1'b1;
              wait_cnt  <= DELAY_W'(1);
              state     <= RWAIT;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_slave_port_burst_split.sv
// tb_slave_port_burst_split: directed scenario tests for the serial slave port
module tb_slave_port_burst_split;
  logic        clk = 1'b0, reset = 1'b1;
  logic [5:0]  slave_delay = '0;
  logic        read_en = 0, write_en = 0, master_valid = 0, master_ready = 1;
  logic        rx_address = 0, rx_burst = 0, rx_data = 0;
  logic        slave_ready, slave_valid, tx_data, split_en, mem_wr_en, mem_rd_en, busy;
  logic [11:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;
  int checks = 0, errors = 0;
  logic [11:0] wa_q[$], ra_q[$];
  logic [7:0]  wd_q[$];
  logic        bits[$];
  int cyc = 0, rd_cyc, sv_rise, split_cnt, split_first, hold_err;
  logic sv_prev = 0, stall_prev = 0, tx_prev = 0;

  slave_port_burst_split dut (
    .clk(clk), .reset(reset), .slave_delay(slave_delay), .read_en(read_en),
    .write_en(write_en), .master_valid(master_valid), .master_ready(master_ready),
    .rx_address(rx_address), .rx_burst(rx_burst), .rx_data(rx_data),
    .slave_ready(slave_ready), .slave_valid(slave_valid), .tx_data(tx_data),
    .split_en(split_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en), .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;
  assign mem_rdata = (mem_addr == 12'h040) ? 8'h5C : (mem_addr[7:0] ^ 8'h96);

  always @(negedge clk) begin
    cyc++;
    if (mem_wr_en) begin wa_q.push_back(mem_addr); wd_q.push_back(mem_wdata); end
    if (mem_rd_en) begin ra_q.push_back(mem_addr); if (ra_q.size() == 1) rd_cyc = cyc; end
    if (split_en) begin if (split_cnt == 0) split_first = cyc; split_cnt++; end
    if (slave_valid && !sv_prev && sv_rise < 0) sv_rise = cyc;
    sv_prev = slave_valid;
    if (slave_valid && master_ready) bits.push_back(tx_data);
    if (stall_prev && slave_valid && tx_data !== tx_prev) hold_err++;
    stall_prev = slave_valid && !master_ready;
    tx_prev = tx_data;
  end

  task automatic clear_logs();
    wa_q.delete(); wd_q.delete(); ra_q.delete(); bits.delete();
    rd_cyc = -1; sv_rise = -1; split_cnt = 0; split_first = -1; hold_err = 0;
  endtask

  task automatic send_addr(input logic wr, input logic [11:0] a, input logic [7:0] b, input logic [5:0] d);
    slave_delay = d;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      master_valid = 1; write_en = wr; read_en = !wr;
      rx_address = a[i]; rx_burst = (i < 8) ? b[i] : 1'b0;
    end
    write_en = 0; read_en = 0;
  endtask

  task automatic do_write(input logic [11:0] a, input logic [7:0] b, input logic [23:0] d, input int n);
    send_addr(1'b1, a, b, 6'd0);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      rx_data = d[i];
    end
    @(posedge clk); #1;
    master_valid = 0;
  endtask

  task automatic settle();
    int k;
    for (k = 0; k < 200 && busy; k++) @(posedge clk);
    if (busy) begin errors++; $display("FAIL settle: busy=%b required 0", busy); end
    checks++;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic do_read(input logic [11:0] a, input logic [7:0] b, input logic [5:0] d, input logic toggle);
    int k;
    master_ready = 1;
    send_addr(1'b0, a, b, d);
    @(posedge clk); #1;
    master_valid = 0;
    for (k = 0; k < 400 && busy; k++) begin
      @(posedge clk); #1;
      master_ready = toggle ? ~master_ready : 1'b1;
    end
    checks++;
    if (busy) begin errors++; $display("FAIL read_timeout: busy=%b required 0", busy); end
    master_ready = 1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] get_byte(input int k);
    logic [7:0] v;
    for (int j = 0; j < 8; j++) v[j] = bits[8*k+j];
    return v;
  endfunction

  task automatic test_reset();
    #12;
    checks++;
    if ({slave_valid, tx_data, split_en, mem_wr_en, mem_rd_en, busy, slave_ready} !== 7'b0000001 ||
        mem_addr !== 12'h0 || mem_wdata !== 8'h0) begin
      errors++;
      $display("FAIL reset_outputs: flags=%b addr=%h wdata=%h required 0000001 000 00",
               {slave_valid, tx_data, split_en, mem_wr_en, mem_rd_en, busy, slave_ready}, mem_addr, mem_wdata);
    end
    @(posedge clk); #1;
    reset = 0;
  endtask

  task automatic test_single_write();
    clear_logs();
    do_write(12'h123, 8'd0, 24'h0000A5, 8);
    settle();
    checks++;
    if (wa_q.size() !== 1) begin errors++; $display("FAIL wr1_count: %0d required 1", wa_q.size()); end
    else begin
      checks++;
      if (wa_q[0] !== 12'h123 || wd_q[0] !== 8'hA5) begin
        errors++; $display("FAIL wr1_data: addr=%h data=%h required 123 a5", wa_q[0], wd_q[0]);
      end
    end
    checks++;
    if (busy !== 1'b0 || slave_ready !== 1'b1) begin
      errors++; $display("FAIL wr1_idle: busy=%b ready=%b required 0 1", busy, slave_ready);
    end
  endtask

  task automatic test_burst_write();
    logic [11:0] ea[3] = '{12'hFFE, 12'hFFF, 12'h000};
    logic [7:0]  ed[3] = '{8'h11, 8'h22, 8'h33};
    clear_logs();
    do_write(12'hFFE, 8'd2, 24'h332211, 24);
    settle();
    checks++;
    if (wa_q.size() !== 3) begin errors++; $display("FAIL wr3_count: %0d required 3", wa_q.size()); end
    else for (int i = 0; i < 3; i++) begin
      checks++;
      if (wa_q[i] !== ea[i] || wd_q[i] !== ed[i]) begin
        errors++; $display("FAIL wr3_beat%0d: addr=%h data=%h required %h %h", i, wa_q[i], wd_q[i], ea[i], ed[i]);
      end
    end
  endtask

  task automatic test_short_read();
    logic exp[8] = '{0, 0, 1, 1, 1, 0, 1, 0};
    clear_logs();
    do_read(12'h040, 8'd0, 6'd2, 1'b0);
    checks++;
    if (split_cnt !== 0) begin errors++; $display("FAIL rd_short_split: cycles=%0d required 0", split_cnt); end
    checks++;
    if (sv_rise - rd_cyc !== 2) begin errors++; $display("FAIL rd_short_latency: %0d required 2", sv_rise - rd_cyc); end
    checks++;
    if (bits.size() !== 8) begin errors++; $display("FAIL rd_short_bits: %0d required 8", bits.size()); end
    else for (int i = 0; i < 8; i++) begin
      checks++;
      if (bits[i] !== exp[i]) begin errors++; $display("FAIL rd_short_bit%0d: %b required %b", i, bits[i], exp[i]); end
    end
  endtask

  task automatic test_split_read();
    clear_logs();
    do_read(12'h200, 8'd0, 6'd9, 1'b0);
    checks++;
    if (split_cnt !== 9 || split_first !== rd_cyc) begin
      errors++; $display("FAIL rd_split_window: cycles=%0d start=%0d required 9 %0d", split_cnt, split_first, rd_cyc);
    end
    checks++;
    if (sv_rise - rd_cyc !== 9) begin errors++; $display("FAIL rd_split_latency: %0d required 9", sv_rise - rd_cyc); end
    checks++;
    if (bits.size() !== 8) begin errors++; $display("FAIL rd_split_bits: %0d required 8", bits.size()); end
    else begin
      checks++;
      if (get_byte(0) !== 8'h96) begin errors++; $display("FAIL rd_split_data: %h required 96", get_byte(0)); end
    end
  endtask

  task automatic test_burst_read();
    logic [11:0] ea[3] = '{12'h0A0, 12'h0A1, 12'h0A2};
    logic [7:0]  ed[3] = '{8'h36, 8'h37, 8'h34};
    clear_logs();
    do_read(12'h0A0, 8'd2, 6'd3, 1'b1);
    checks++;
    if (ra_q.size() !== 3) begin errors++; $display("FAIL rd3_strobes: %0d required 3", ra_q.size()); end
    else for (int i = 0; i < 3; i++) begin
      checks++;
      if (ra_q[i] !== ea[i]) begin errors++; $display("FAIL rd3_addr%0d: %h required %h", i, ra_q[i], ea[i]); end
    end
    checks++;
    if (bits.size() !== 24) begin errors++; $display("FAIL rd3_bits: %0d required 24", bits.size()); end
    else for (int i = 0; i < 3; i++) begin
      checks++;
      if (get_byte(i) !== ed[i]) begin errors++; $display("FAIL rd3_data%0d: %h required %h", i, get_byte(i), ed[i]); end
    end
    checks++;
    if (hold_err !== 0) begin errors++; $display("FAIL rd3_hold: changes=%0d required 0", hold_err); end
    checks++;
    if (split_cnt !== 0) begin errors++; $display("FAIL rd3_split: cycles=%0d required 0", split_cnt); end
  endtask

  task automatic test_reset_mid_write();
    clear_logs();
    send_addr(1'b1, 12'h300, 8'd0, 6'd0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      rx_data = i[0];
    end
    @(posedge clk); #1;
    reset = 1;
    #1;
    checks++;
    if ({slave_valid, tx_data, split_en, mem_wr_en, mem_rd_en, busy, slave_ready} !== 7'b0000001 ||
        mem_addr !== 12'h0 || mem_wdata !== 8'h0) begin
      errors++;
      $display("FAIL rst_mid_outputs: flags=%b addr=%h wdata=%h required 0000001 000 00",
               {slave_valid, tx_data, split_en, mem_wr_en, mem_rd_en, busy, slave_ready}, mem_addr, mem_wdata);
    end
    master_valid = 0;
    @(posedge clk); #1;
    reset = 0;
    repeat (12) @(posedge clk);
    #1;
    checks++;
    if (wa_q.size() !== 0) begin errors++; $display("FAIL rst_mid_nowrite: strobes=%0d required 0", wa_q.size()); end
    do_write(12'h055, 8'd0, 24'h00003C, 8);
    settle();
    checks++;
    if (wa_q.size() !== 1) begin errors++; $display("FAIL rst_next_count: %0d required 1", wa_q.size()); end
    else begin
      checks++;
      if (wa_q[0] !== 12'h055 || wd_q[0] !== 8'h3C) begin
        errors++; $display("FAIL rst_next_data: addr=%h data=%h required 055 3c", wa_q[0], wd_q[0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_burst_write();
    test_short_read();
    test_split_read();
    test_burst_read();
    test_reset_mid_write();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
